led_strip_engine: RTL and testbench
===================================

# led_strip_engine

Parametrised successor to the fixed 10-LED breadboard strip controller. It takes one 4-bit command per `op_valid` pulse and holds power, mode, colour and undo state in synchronous registers. It generates solid, blink and rotating-rainbow patterns from a programmable step timer, and applies brightness scaling to every pixel. It sits between the command source and the LED strip driver.

## Interface
- `NUM_LEDS`, 10: number of pixels on the strip; must be ≥1.
- `STEP_DIV`, 1: clock cycles per animation step; must be ≥1.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `op_valid`  in  1  single-cycle command strobe.
- `op_code`  in  4  command; sampled only when `op_valid`=1.
- `strip`  out  NUM_LEDS×24  pixel colours, `{R,G,B}` per pixel; pixel 0 is in the LSBs.
- `mode`  out  2  current mode: 0 solid, 1 blink, 2 rainbow.
- `color_code`  out  3  current colour/palette index.
- `brightness`  out  3  current brightness level, 0..7.
- `power`  out  1  system is on.

## Operation
- **Reset values:** `power`=0, `mode`=0, `color_code`=0, `brightness`=0, undo register `prev_color`=0, blink `phase`=1, rainbow `offset`=0, step counter=0, `strip`=0.
- **While `power`=0:**
  - Every op except 1 is ignored.
  - `strip` is held at 0.
- **Op codes:**
  - 0: no-op.
  - 1: power on. Sets `power`=1, `mode`=0, `color_code`=0, `prev_color`=0, `brightness`=7.
  - 2: next mode, 0→1→2→0.
  - 3: previous mode, 0→2→1→0.
  - 4: next colour, wraps 7→0. Sets `prev_color` to the old colour.
  - 5: undo. Sets `color_code`=`prev_color`; `prev_color` is unchanged, so repeating op 5 is idempotent.
  - 6: brightness +1, saturating at 7.
  - 7: brightness −1, saturating at 0.
  - 8–15: direct select, `color_code`=`op_code[2:0]`. If this differs from the current colour, `prev_color` gets the old colour. Selecting the current colour is a full no-op.
- **Solid colour table** (index: value): 0 FF0000, 1 00FF00, 2 0000FF, 3 FFFF00, 4 FF6400, 5 FF00FF, 6 6400FF, 7 FFFFFF.
- **Mode 0, solid:** every pixel shows the solid colour for `color_code`.
- **Mode 1, blink:**
  - Every pixel shows the solid colour while `phase`=1, and 0 while `phase`=0.
  - `phase` toggles on each step tick.
  - Entering mode 1 forces `phase`=1.
- **Mode 2, rainbow:**
  - Pixel i shows `palette[color_code][(i%10 + 10 − offset) % 10]`.
  - The palette is an 8×10 table of 24-bit colours.
  - `offset` counts 0..9 and increments on each step tick, wrapping 9→0. `offset` runs in all modes.
- **Step timer:** counts 0..STEP_DIV−1; step tick = counter at STEP_DIV−1. It runs only while `power`=1.
- **Brightness scaling:**
  - Each 8-bit channel output = (c × (brightness+1)) >> 3, using an 11-bit intermediate.
  - Brightness 7 leaves values unchanged; brightness 0 gives c>>3.

## Timing
- Op accepted at edge k:
  - `mode`, `color_code`, `brightness` and `power` show the new values after edge k.
  - `strip` reflects the new state after edge k+1 (pixel path registered, latency 1).
- A step tick at edge k changes `phase`/`offset` at edge k; `strip` follows at k+1.
- A command and a step tick in the same cycle both take effect. A mode change into blink overrides the toggle, so `phase`=1.
- `rst` wins over `op_valid` and over the tick. Reset mid-animation returns everything to the reset values at that edge.
- `op_valid` may be asserted every cycle; there is no backpressure.
- A repeated op 1 while on restores the defaults. It does not reset `offset` or the step counter.

## Structure
- Package `led_pkg` holds:
  - op-code localparams;
  - the mode enum `led_mode_t` with values SOLID, BLINK, RAINBOW;
  - the solid colour table;
  - the 8×10 rainbow palette constant;
  - the default brightness (7).
- Sub-module `led_brightness_scale`: combinational 24-bit pixel × 3-bit brightness scaler, instantiated once per pixel in a generate loop.
- Control state, step timer and the pixel output register live in the top module.

## Test plan
- Reset, then op 2 with no op 1 → `power`=0, `mode`=0, `strip`=0.
- Op 1 → `brightness`=7, `color_code`=0; after 1 more edge every pixel = FF0000. Then op 7 twice → `brightness`=5, every pixel = BF0000.
- Op 8+3 → yellow; op 8+3 again → no change; op 5 → `color_code`=0 (red); op 5 again → still 0. Op 4 from 7 → 0.
- Op 2, STEP_DIV=4 → pixels alternate FF0000 / 000000 every 4 cycles, starting lit. Op 6 at 7 → stays 7; op 7 at 0 → stays 0.
- Mode 2, palette 0, NUM_LEDS=10, STEP_DIV=1 → pixel 0 = 094074 at offset 0. The pattern shifts by one pixel per cycle and pixel 0 repeats every 10 steps. Repeat with NUM_LEDS=13: pixel 10 = pixel 0.
- Assert `rst` during rainbow with `op_valid`=1 and op 4 → all outputs return to the reset values on that edge.

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg: shared constants and types for the LED strip engine.
//   - op-code values for the 4-bit command bus
//   - led_mode_t: SOLID / BLINK / RAINBOW pattern selection
//   - SOLID_COLORS: 8-entry {R,G,B} table indexed by colour code
//   - RAINBOW_PALETTE: 8 palettes x 10 entries, indexed [colour][position]
//   - DEFAULT_BRIGHTNESS: level restored by a power-on command
package led_pkg;

    localparam logic [3:0] OP_NOP        = 4'd0;
    localparam logic [3:0] OP_POWER_ON   = 4'd1;
    localparam logic [3:0] OP_MODE_NEXT  = 4'd2;
    localparam logic [3:0] OP_MODE_PREV  = 4'd3;
    localparam logic [3:0] OP_COLOR_NEXT = 4'd4;
    localparam logic [3:0] OP_UNDO       = 4'd5;
    localparam logic [3:0] OP_BRIGHT_UP  = 4'd6;
    localparam logic [3:0] OP_BRIGHT_DN  = 4'd7;

    typedef enum logic [1:0] {
        SOLID   = 2'd0,
        BLINK   = 2'd1,
        RAINBOW = 2'd2
    } led_mode_t;

    localparam logic [2:0] DEFAULT_BRIGHTNESS = 3'd7;
    localparam int         PALETTE_LEN        = 10;

    localparam logic [23:0] SOLID_COLORS [8] = '{
        24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
        24'hFF6400, 24'hFF00FF, 24'h6400FF, 24'hFFFFFF
    };

    // Each palette sweeps red upward along the strip; green marks the
    // palette number and blue drifts with both.
    localparam logic [23:0] RAINBOW_PALETTE [8][PALETTE_LEN] = '{
        '{24'h094074, 24'h194075, 24'h294076, 24'h394077, 24'h494078,
          24'h594079, 24'h69407A, 24'h79407B, 24'h89407C, 24'h99407D},
        '{24'h095075, 24'h195076, 24'h295077, 24'h395078, 24'h495079,
          24'h59507A, 24'h69507B, 24'h79507C, 24'h89507D, 24'h99507E},
        '{24'h096076, 24'h196077, 24'h296078, 24'h396079, 24'h49607A,
          24'h59607B, 24'h69607C, 24'h79607D, 24'h89607E, 24'h99607F},
        '{24'h097077, 24'h197078, 24'h297079, 24'h39707A, 24'h49707B,
          24'h59707C, 24'h69707D, 24'h79707E, 24'h89707F, 24'h997080},
        '{24'h098078, 24'h198079, 24'h29807A, 24'h39807B, 24'h49807C,
          24'h59807D, 24'h69807E, 24'h79807F, 24'h898080, 24'h998081},
        '{24'h099079, 24'h19907A, 24'h29907B, 24'h39907C, 24'h49907D,
          24'h59907E, 24'h69907F, 24'h799080, 24'h899081, 24'h999082},
        '{24'h09A07A, 24'h19A07B, 24'h29A07C, 24'h39A07D, 24'h49A07E,
          24'h59A07F, 24'h69A080, 24'h79A081, 24'h89A082, 24'h99A083},
        '{24'h09B07B, 24'h19B07C, 24'h29B07D, 24'h39B07E, 24'h49B07F,
          24'h59B080, 24'h69B081, 24'h79B082, 24'h89B083, 24'h99B084}
    };

endpackage

// File: rtl/led_strip_engine_if.sv
// led_strip_engine_if: command and status bundle between a command source
// (master) and the LED strip engine (slave).
//   op_valid/op_code : single-cycle command strobe and 4-bit op, no backpressure;
//                      a command is taken on every rising edge op_valid is high
//   strip            : NUM_LEDS x 24-bit {R,G,B}, pixel 0 in the LSBs
//   mode, color_code, brightness, power : current control state
interface led_strip_engine_if #(
    parameter int NUM_LEDS = 10
);
    import led_pkg::*;

    logic                    op_valid;
    logic [3:0]              op_code;
    logic [NUM_LEDS*24-1:0]  strip;
    led_mode_t               mode;
    logic [2:0]              color_code;
    logic [2:0]              brightness;
    logic                    power;

    modport master (
        output op_valid, op_code,
        input  strip, mode, color_code, brightness, power
    );

    modport slave (
        input  op_valid, op_code,
        output strip, mode, color_code, brightness, power
    );
endinterface

// File: rtl/led_brightness_scale.sv
// led_brightness_scale: combinational per-pixel brightness scaler.
//   i_pixel      : 24-bit {R,G,B} colour
//   i_brightness : level 0..7
//   o_pixel      : each channel = (c * (level + 1)) >> 3
module led_brightness_scale (
    input  logic [23:0] i_pixel,
    input  logic [2:0]  i_brightness,
    output logic [23:0] o_pixel
);
    logic [10:0] w_factor;

    assign w_factor = {8'd0, i_brightness} + 11'd1;

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        // 255 * 8 = 2040 fits in 11 bits, so the product never overflows.
        logic [10:0] w_prod;
        assign w_prod = {3'd0, i_pixel[ch*8 +: 8]} * w_factor;
        assign o_pixel[ch*8 +: 8] = 8'(w_prod >> 3);
    end
endmodule

// File: rtl/led_strip_engine.sv
// led_strip_engine: command-driven LED strip pattern generator.
//   clk  : system clock, all state changes on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : slave side of led_strip_engine_if (commands in, strip/status out)
// Control state (power, mode, colour, undo, brightness), the animation step
// timer and the registered pixel output all live here. The pixel path is
// one register deep: strip shows the state as it was after the previous edge.
module led_strip_engine
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 10,
    parameter int STEP_DIV = 1
) (
    input logic                clk,
    input logic                rst,
    led_strip_engine_if.slave  bus
);
    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic                   r_power,      w_power;
    led_mode_t              r_mode,       w_mode;
    logic [2:0]             r_color,      w_color;
    logic [2:0]             r_prev_color, w_prev_color;
    logic [2:0]             r_brightness, w_brightness;
    logic                   r_phase,      w_phase;
    logic [3:0]             r_offset,     w_offset;
    logic [CW-1:0]          r_step_cnt,   w_step_cnt;
    logic [NUM_LEDS*24-1:0] r_strip,      w_strip_next;
    logic                   w_tick;

    assign w_tick = r_power && (r_step_cnt == CW'(STEP_DIV - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_power      <= 1'b0;
            r_mode       <= SOLID;
            r_color      <= 3'd0;
            r_prev_color <= 3'd0;
            r_brightness <= 3'd0;
            r_phase      <= 1'b1;
            r_offset     <= 4'd0;
            r_step_cnt   <= '0;
            r_strip      <= '0;
        end else begin
            r_power      <= w_power;
            r_mode       <= w_mode;
            r_color      <= w_color;
            r_prev_color <= w_prev_color;
            r_brightness <= w_brightness;
            r_phase      <= w_phase;
            r_offset     <= w_offset;
            r_step_cnt   <= w_step_cnt;
            r_strip      <= r_power ? w_strip_next : '0;
        end
    end

    // Next-state logic: step timer first, then the command on top of it.
    always_comb begin
        w_power      = r_power;
        w_mode       = r_mode;
        w_color      = r_color;
        w_prev_color = r_prev_color;
        w_brightness = r_brightness;
        w_phase      = r_phase;
        w_offset     = r_offset;
        w_step_cnt   = r_step_cnt;

        if (r_power) begin
            w_step_cnt = w_tick ? '0 : r_step_cnt + CW'(1);
        end
        if (w_tick) begin
            w_phase  = ~r_phase;
            w_offset = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
        end

        // While off, only power-on is honoured.
        if (bus.op_valid && (r_power || bus.op_code == OP_POWER_ON)) begin
            if (bus.op_code[3]) begin
                if (bus.op_code[2:0] != r_color) begin
                    w_prev_color = r_color;
                    w_color      = bus.op_code[2:0];
                end
            end else begin
                case (bus.op_code)
                    OP_POWER_ON: begin
                        w_power      = 1'b1;
                        w_mode       = SOLID;
                        w_color      = 3'd0;
                        w_prev_color = 3'd0;
                        w_brightness = DEFAULT_BRIGHTNESS;
                    end
                    OP_MODE_NEXT: begin
                        case (r_mode)
                            SOLID:   w_mode = BLINK;
                            BLINK:   w_mode = RAINBOW;
                            default: w_mode = SOLID;
                        endcase
                    end
                    OP_MODE_PREV: begin
                        case (r_mode)
                            SOLID:   w_mode = RAINBOW;
                            BLINK:   w_mode = SOLID;
                            default: w_mode = BLINK;
                        endcase
                    end
                    OP_COLOR_NEXT: begin
                        w_prev_color = r_color;
                        w_color      = r_color + 3'd1;
                    end
                    OP_UNDO:      w_color = r_prev_color;
                    OP_BRIGHT_UP: if (r_brightness != 3'd7) w_brightness = r_brightness + 3'd1;
                    OP_BRIGHT_DN: if (r_brightness != 3'd0) w_brightness = r_brightness - 3'd1;
                    default: ;
                endcase
            end
        end

        // Entering blink always starts lit, even if a tick lands on the same edge.
        if (w_mode == BLINK && r_mode != BLINK) begin
            w_phase = 1'b1;
        end
    end

    // Output logic: per-pixel colour selection and brightness scaling.
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_pix
        localparam int PIX_MOD = gi % PALETTE_LEN;
        logic [4:0]  w_sum;
        logic [3:0]  w_idx;
        logic [23:0] w_raw;
        logic [23:0] w_scaled;

        always_comb begin
            // (i%10 + 10 - offset) lies in 1..19, so one conditional subtract wraps it.
            w_sum = 5'(PIX_MOD + PALETTE_LEN) - {1'b0, r_offset};
            w_idx = (w_sum >= 5'd10) ? 4'(w_sum - 5'd10) : w_sum[3:0];
            w_raw = '0;
            case (r_mode)
                SOLID:   w_raw = SOLID_COLORS[r_color];
                BLINK:   w_raw = r_phase ? SOLID_COLORS[r_color] : 24'h000000;
                RAINBOW: w_raw = RAINBOW_PALETTE[r_color][w_idx];
                default: w_raw = '0;
            endcase
        end

        led_brightness_scale u_scale (
            .i_pixel      (w_raw),
            .i_brightness (r_brightness),
            .o_pixel      (w_scaled)
        );

        assign w_strip_next[gi*24 +: 24] = w_scaled;
    end

    assign bus.strip      = r_strip;
    assign bus.mode       = r_mode;
    assign bus.color_code = r_color;
    assign bus.brightness = r_brightness;
    assign bus.power      = r_power;
endmodule

// File: tb/tb_led_strip_engine.sv
// Bench for led_strip_engine: two instances (10 LEDs / step 4, 13 LEDs / step 1)
// share one command stream and are checked every cycle against a behavioural
// model, with literal expectations at key points of the directed sequence.
module tb_led_strip_engine;
    localparam int MAXW = 13 * 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_strip_engine_if #(.NUM_LEDS(10)) bus0 ();
    led_strip_engine_if #(.NUM_LEDS(13)) bus1 ();

    led_strip_engine #(.NUM_LEDS(10), .STEP_DIV(4)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    led_strip_engine #(.NUM_LEDS(13), .STEP_DIV(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int nl [2] = '{10, 13};
    int sd [2] = '{4, 1};
    int solid_tab [8] = '{'hFF0000, 'h00FF00, 'h0000FF, 'hFFFF00,
                          'hFF6400, 'hFF00FF, 'h6400FF, 'hFFFFFF};

    int m_power [2], m_mode [2], m_color [2], m_prev [2];
    int m_bright [2], m_phase [2], m_off [2], m_cnt [2];
    logic [MAXW-1:0] m_strip [2];

    int tests = 0;
    int fails = 0;

    // Rainbow palette p, position j: red climbs by 0x10 per position,
    // green by 0x10 per palette, blue by one per position and per palette.
    function automatic logic [23:0] pal(int p, int j);
        int r, g, b;
        r = 9 + 16 * j;
        g = 64 + 16 * p;
        b = 116 + p + j;
        return 24'(r * 65536 + g * 256 + b);
    endfunction

    function automatic logic [23:0] model_pixel(int k, int i);
        int base, res, ch;
        case (m_mode[k])
            0:       base = solid_tab[m_color[k]];
            1:       base = m_phase[k] ? solid_tab[m_color[k]] : 0;
            default: base = int'(pal(m_color[k], ((i % 10) + 10 - m_off[k]) % 10));
        endcase
        res = 0;
        for (int s = 0; s < 3; s++) begin
            ch  = (base >> (8 * s)) & 255;
            res = res + (((ch * (m_bright[k] + 1)) / 8) << (8 * s));
        end
        return 24'(res);
    endfunction

    task automatic model_edge(int k, bit r, bit v, int op);
        bit tick;
        if (r) begin
            m_power[k] = 0; m_mode[k] = 0; m_color[k] = 0; m_prev[k] = 0;
            m_bright[k] = 0; m_phase[k] = 1; m_off[k] = 0; m_cnt[k] = 0;
            m_strip[k] = '0;
            return;
        end
        m_strip[k] = '0;
        if (m_power[k] != 0)
            for (int i = 0; i < nl[k]; i++) m_strip[k][i*24 +: 24] = model_pixel(k, i);
        tick = (m_power[k] != 0) && (m_cnt[k] == sd[k] - 1);
        if (m_power[k] != 0) m_cnt[k] = (m_cnt[k] + 1) % sd[k];
        if (tick) begin
            m_phase[k] = 1 - m_phase[k];
            m_off[k]   = (m_off[k] + 1) % 10;
        end
        if (v && (m_power[k] != 0 || op == 1)) begin
            if (op >= 8) begin
                if (op % 8 != m_color[k]) begin
                    m_prev[k]  = m_color[k];
                    m_color[k] = op % 8;
                end
            end else begin
                case (op)
                    1: begin
                        m_power[k] = 1; m_mode[k] = 0; m_color[k] = 0;
                        m_prev[k] = 0; m_bright[k] = 7;
                    end
                    2: begin
                        m_mode[k] = (m_mode[k] + 1) % 3;
                        if (m_mode[k] == 1) m_phase[k] = 1;
                    end
                    3: begin
                        m_mode[k] = (m_mode[k] + 2) % 3;
                        if (m_mode[k] == 1) m_phase[k] = 1;
                    end
                    4: begin m_prev[k] = m_color[k]; m_color[k] = (m_color[k] + 1) % 8; end
                    5: m_color[k] = m_prev[k];
                    6: if (m_bright[k] < 7) m_bright[k]++;
                    7: if (m_bright[k] > 0) m_bright[k]--;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic chk(string name, logic [MAXW-1:0] act, logic [MAXW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] px0(int i);
        return bus0.strip[i*24 +: 24];
    endfunction

    function automatic logic [23:0] px1(int i);
        return bus1.strip[i*24 +: 24];
    endfunction

    task automatic compare_all();
        chk("power0",  MAXW'(bus0.power),      MAXW'(m_power[0]));
        chk("mode0",   MAXW'(bus0.mode),       MAXW'(m_mode[0]));
        chk("color0",  MAXW'(bus0.color_code), MAXW'(m_color[0]));
        chk("bright0", MAXW'(bus0.brightness), MAXW'(m_bright[0]));
        chk("strip0",  MAXW'(bus0.strip),      m_strip[0]);
        chk("power1",  MAXW'(bus1.power),      MAXW'(m_power[1]));
        chk("mode1",   MAXW'(bus1.mode),       MAXW'(m_mode[1]));
        chk("color1",  MAXW'(bus1.color_code), MAXW'(m_color[1]));
        chk("bright1", MAXW'(bus1.brightness), MAXW'(m_bright[1]));
        chk("strip1",  MAXW'(bus1.strip),      m_strip[1]);
    endtask

    // One clock: drive, take the edge, advance the model, check 1 time unit later.
    task automatic cycle(bit r, bit v, int op);
        rst = r;
        bus0.op_valid = v;  bus1.op_valid = v;
        bus0.op_code  = 4'(op); bus1.op_code = 4'(op);
        @(posedge clk);
        model_edge(0, r, v, op);
        model_edge(1, r, v, op);
        #1;
        compare_all();
    endtask

    initial begin
        bit r, v;
        int op, n;
        bus0.op_valid = 1'b0; bus1.op_valid = 1'b0;
        bus0.op_code  = 4'd0; bus1.op_code  = 4'd0;

        // Reset, then commands while off.
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        chk("reset_strip", MAXW'(bus0.strip), '0);
        cycle(0, 1, 2);
        chk("off_mode",  MAXW'(bus0.mode), MAXW'(0));
        chk("off_power", MAXW'(bus0.power), MAXW'(0));
        chk("off_strip", MAXW'(bus1.strip), '0);

        // Power on, solid red, brightness steps.
        cycle(0, 1, 1);
        chk("on_bright", MAXW'(bus0.brightness), MAXW'(7));
        chk("on_color",  MAXW'(bus0.color_code), MAXW'(0));
        cycle(0, 0, 0);
        chk("on_red_px0", MAXW'(px0(0)), MAXW'(24'hFF0000));
        chk("on_red_px9", MAXW'(px0(9)), MAXW'(24'hFF0000));
        cycle(0, 1, 7);
        cycle(0, 1, 7);
        cycle(0, 0, 0);
        chk("dim_bright", MAXW'(bus0.brightness), MAXW'(5));
        chk("dim_px0",    MAXW'(px0(0)), MAXW'(24'hBF0000));
        cycle(0, 1, 6);
        cycle(0, 1, 6);
        chk("up_bright", MAXW'(bus0.brightness), MAXW'(7));

        // Direct select, repeat select, undo, wrap.
        cycle(0, 1, 11);
        chk("sel_yellow", MAXW'(bus0.color_code), MAXW'(3));
        cycle(0, 1, 11);
        chk("sel_again", MAXW'(bus0.color_code), MAXW'(3));
        chk("yellow_px", MAXW'(px0(4)), MAXW'(24'hFFFF00));
        cycle(0, 1, 5);
        chk("undo1", MAXW'(bus0.color_code), MAXW'(0));
        cycle(0, 1, 5);
        chk("undo2", MAXW'(bus0.color_code), MAXW'(0));
        cycle(0, 1, 15);
        chk("sel7", MAXW'(bus0.color_code), MAXW'(7));
        cycle(0, 1, 4);
        chk("wrap7to0", MAXW'(bus0.color_code), MAXW'(0));

        // Brightness saturation at both ends.
        repeat (8) cycle(0, 1, 7);
        chk("bright_floor", MAXW'(bus0.brightness), MAXW'(0));
        cycle(0, 1, 7);
        chk("bright_floor2", MAXW'(bus0.brightness), MAXW'(0));
        cycle(0, 0, 0);
        chk("bright0_px", MAXW'(px0(0)), MAXW'(24'h1F0000));
        repeat (8) cycle(0, 1, 6);
        chk("bright_ceil", MAXW'(bus0.brightness), MAXW'(7));

        // Blink: starts lit, then model tracks the toggling.
        cycle(0, 1, 2);
        chk("blink_mode", MAXW'(bus0.mode), MAXW'(1));
        cycle(0, 0, 0);
        chk("blink_lit", MAXW'(px0(0)), MAXW'(24'hFF0000));
        repeat (16) cycle(0, 0, 0);

        // Rainbow from a fresh power-on.
        cycle(1, 0, 0);
        cycle(0, 1, 1);
        cycle(0, 1, 2);
        cycle(0, 1, 2);
        chk("rb_mode", MAXW'(bus1.mode), MAXW'(2));
        n = 0;
        while (m_off[1] != 0 && n < 12) begin
            cycle(0, 0, 0);
            n++;
        end
        chk("rb_offset_wait", MAXW'(m_off[1] == 0), MAXW'(1));
        cycle(0, 0, 0);
        chk("rb_px0",  MAXW'(px1(0)),  MAXW'(24'h094074));
        chk("rb_px10", MAXW'(px1(10)), MAXW'(24'h094074));
        cycle(0, 0, 0);
        chk("rb_shift", MAXW'(px1(1)), MAXW'(24'h094074));
        repeat (9) cycle(0, 0, 0);
        chk("rb_period", MAXW'(px1(0)), MAXW'(24'h094074));

        // Random commands with occasional resets.
        repeat (500) begin
            r  = ($urandom_range(0, 149) == 0);
            v  = ($urandom_range(0, 9) < 7);
            op = $urandom_range(0, 15);
            if (m_power[0] == 0 && $urandom_range(0, 3) == 0) op = 1;
            cycle(r, v, op);
        end

        // Reset mid-rainbow beats a simultaneous command.
        cycle(0, 1, 1);
        cycle(0, 1, 2);
        cycle(0, 1, 2);
        repeat (5) cycle(0, 0, 0);
        cycle(1, 1, 4);
        chk("rst_power",  MAXW'(bus0.power),      MAXW'(0));
        chk("rst_mode",   MAXW'(bus0.mode),       MAXW'(0));
        chk("rst_color",  MAXW'(bus0.color_code), MAXW'(0));
        chk("rst_bright", MAXW'(bus0.brightness), MAXW'(0));
        chk("rst_strip0", MAXW'(bus0.strip), '0);
        chk("rst_strip1", MAXW'(bus1.strip), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
